cursor_move_scheduler: RTL and testbench

// - Arbiter and sequencer for the cursor position datapath. Two movement sources
//   (e.g. mouse decoder, button stepper) offer (dx,dy) steps via valid/ready.
// - At most one step is granted per rate tick, round-robin. The granted step is

---
 rtl/cursor_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 23 ++
 rtl/cursor_move_scheduler.sv | 144 ++++++++++++++
 tb/tb_cursor_move_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cursor_pkg.sv
// Shared constants, state encoding and clip helper for the cursor move scheduler.
package cursor_pkg;

   localparam int unsigned HBP      = 144;
   localparam int unsigned HFP      = 784;
   localparam int unsigned VBP      = 31;
   localparam int unsigned VFP      = 511;
   localparam int unsigned XMAX     = HFP - 1;
   localparam int unsigned YMAX     = VFP - 1;
   localparam int unsigned CENTRE_X = (HBP + HFP) / 2;
   localparam int unsigned CENTRE_Y = (VBP + VFP) / 2;

   localparam int unsigned PW = 10;
   localparam int unsigned SW = 5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PULSE_HI = 2'd1,
      PULSE_LO = 2'd2
   } state_e;

   // Step limited to the distance left before the window edge.
   function automatic logic [SW-1:0] clip_step(input logic [SW-1:0] step,
                                               input logic [PW-1:0] pos,
                                               input logic [PW-1:0] lim);
      logic [PW-1:0] room;
      room = (pos >= lim) ? '0 : (lim - pos);
      clip_step = ({{(PW-SW){1'b0}}, step} < room) ? step : room[SW-1:0];
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the requester that did not win last time has priority.
module rr_arb2
   import cursor_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic [1:0] gnt_o,
   output logic       gnt_idx_o,
   output logic       gnt_vld_o
);

   always_comb begin
      gnt_idx_o = last_grant_i;
      if (req_i[~last_grant_i]) begin
         gnt_idx_o = ~last_grant_i;
      end else if (req_i[last_grant_i]) begin
         gnt_idx_o = last_grant_i;
      end
      gnt_vld_o = |req_i;
      gnt_o     = gnt_vld_o ? (2'b01 << gnt_idx_o) : 2'b00;
   end

endmodule

// File: rtl/cursor_move_scheduler.sv
// Rate-limited round-robin sequencer for cursor steps: clips each granted step to the
// visible window, strobes the position register and tracks a shadow dot position.
module cursor_move_scheduler
   import cursor_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 500000,
   parameter int unsigned PULSE_CYC = 2
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        recenter,
   input  logic [1:0]  req_valid,
   input  logic [9:0]  req_dx,
   input  logic [9:0]  req_dy,
   output logic [1:0]  req_ready,
   output logic [4:0]  delta_x,
   output logic [4:0]  delta_y,
   output logic        clk_cursor,
   output logic        prev_clk_cursor,
   output logic [9:0]  pos_x,
   output logic [9:0]  pos_y,
   output logic        busy
);

   localparam int unsigned CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned PCW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

   state_e          state_q, state_d;
   logic [CW-1:0]   div_q, div_d;
   logic [PCW-1:0]  pcnt_q, pcnt_d;
   logic [SW-1:0]   dx_q, dx_d, dy_q, dy_d;
   logic [PW-1:0]   px_q, px_d, py_q, py_d;
   logic            last_q, last_d;
   logic            clk_cur_q, prev_q;

   logic            tick, accept;
   logic [1:0]      gnt;
   logic            gnt_idx, gnt_vld;
   logic [SW-1:0]   sel_dx, sel_dy, clip_dx, clip_dy;

   rr_arb2 u_arb (
      .req_i        (req_valid),
      .last_grant_i (last_q),
      .gnt_o        (gnt),
      .gnt_idx_o    (gnt_idx),
      .gnt_vld_o    (gnt_vld)
   );

   assign sel_dx  = gnt_idx ? req_dx[9:5] : req_dx[4:0];
   assign sel_dy  = gnt_idx ? req_dy[9:5] : req_dy[4:0];
   assign clip_dx = clip_step(sel_dx, px_q, PW'(XMAX));
   assign clip_dy = clip_step(sel_dy, py_q, PW'(YMAX));

   assign tick   = (div_q == CW'(TICK_DIV - 1));
   assign accept = (state_q == IDLE) && tick && gnt_vld && !recenter;

   always_comb begin
      state_d   = state_q;
      pcnt_d    = pcnt_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      px_d      = px_q;
      py_d      = py_q;
      last_d    = last_q;
      req_ready = 2'b00;
      div_d     = tick ? '0 : div_q + 1'b1;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               req_ready = gnt;
               dx_d      = clip_dx;
               dy_d      = clip_dy;
               px_d      = px_q + {{(PW-SW){1'b0}}, clip_dx};
               py_d      = py_q + {{(PW-SW){1'b0}}, clip_dy};
               last_d    = gnt_idx;
               pcnt_d    = '0;
               state_d   = PULSE_HI;
            end
         end
         PULSE_HI: begin
            if (pcnt_q == PCW'(PULSE_CYC - 1)) begin
               pcnt_d  = '0;
               state_d = PULSE_LO;
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end
         PULSE_LO: begin
            if (pcnt_q == PCW'(PULSE_CYC - 1)) begin
               pcnt_d  = '0;
               state_d = IDLE;
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end
         default: begin
            pcnt_d  = '0;
            state_d = IDLE;
         end
      endcase

      // Re-centring overrides any position update, including an accept.
      if (recenter) begin
         px_d = PW'(CENTRE_X);
         py_d = PW'(CENTRE_Y);
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q   <= IDLE;
         div_q     <= '0;
         pcnt_q    <= '0;
         dx_q      <= '0;
         dy_q      <= '0;
         px_q      <= PW'(CENTRE_X);
         py_q      <= PW'(CENTRE_Y);
         last_q    <= 1'b1;
         clk_cur_q <= 1'b0;
         prev_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         pcnt_q    <= pcnt_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         px_q      <= px_d;
         py_q      <= py_d;
         last_q    <= last_d;
         clk_cur_q <= (state_d == PULSE_HI);
         prev_q    <= clk_cur_q;
      end
   end

   assign delta_x         = dx_q;
   assign delta_y         = dy_q;
   assign pos_x           = px_q;
   assign pos_y           = py_q;
   assign clk_cursor      = clk_cur_q;
   assign prev_clk_cursor = prev_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_cursor_move_scheduler.sv
// Directed bench for cursor_move_scheduler with TICK_DIV=8, PULSE_CYC=2.
module tb_cursor_move_scheduler;

   logic       clk = 1'b0;
   logic       clr_n = 1'b1;
   logic       recenter = 1'b0;
   logic [1:0] req_valid = 2'b00;
   logic [9:0] req_dx = '0;
   logic [9:0] req_dy = '0;
   logic [1:0] req_ready;
   logic [4:0] delta_x, delta_y;
   logic       clk_cursor, prev_clk_cursor;
   logic [9:0] pos_x, pos_y;
   logic       busy;

   int n_chk = 0;
   int n_fail = 0;
   int edges = 0;
   int viol = 0;
   logic [2:0] bdiv;

   cursor_move_scheduler #(.TICK_DIV(8), .PULSE_CYC(2)) dut (
      .clk             (clk),
      .clr_n           (clr_n),
      .recenter        (recenter),
      .req_valid       (req_valid),
      .req_dx          (req_dx),
      .req_dy          (req_dy),
      .req_ready       (req_ready),
      .delta_x         (delta_x),
      .delta_y         (delta_y),
      .clk_cursor      (clk_cursor),
      .prev_clk_cursor (prev_clk_cursor),
      .pos_x           (pos_x),
      .pos_y           (pos_y),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   // Reference slot counter: tick slot is where it reads 7.
   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) bdiv <= '0;
      else        bdiv <= bdiv + 3'd1;
   end

   always @(negedge clk) begin
      #2;
      if (clr_n) begin
         if (req_ready != 2'b00 && (bdiv != 3'd7 || busy)) viol++;
         if (req_ready == 2'b11) viol++;
         if (clk_cursor && !prev_clk_cursor) edges++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Offer vmask, wait for the accept, then verify deltas, position and a single strobe edge.
   task automatic slot(input logic [1:0] vmask, input logic [1:0] exp_rdy,
                       input logic [4:0] edx, input logic [4:0] edy,
                       input logic [9:0] epx, input logic [9:0] epy,
                       output int waited);
      int e0;
      int n;
      logic [1:0] seen;
      e0 = edges;
      waited = 0;
      req_valid = vmask;
      #1;
      while (req_ready == 2'b00 && waited < 40) begin
         @(negedge clk);
         #1;
         waited++;
      end
      seen = req_ready;
      chk("ready", 32'(seen), 32'(exp_rdy));
      if (seen == 2'b00) begin
         req_valid = 2'b00;
         return;
      end
      @(posedge clk);
      #1;
      req_valid = vmask & ~seen;
      @(negedge clk);
      chk("delta_x", 32'(delta_x), 32'(edx));
      chk("delta_y", 32'(delta_y), 32'(edy));
      chk("pos_x", 32'(pos_x), 32'(epx));
      chk("pos_y", 32'(pos_y), 32'(epy));
      n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("busy_end", 32'(busy), 32'd0);
      chk("edge_count", 32'(edges - e0), 32'd1);
   endtask

   task automatic wait_tick_slot();
      int n;
      n = 0;
      while (bdiv != 3'd7 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("tick_found", 32'(bdiv), 32'd7);
   endtask

   initial begin
      int w;
      int e0;
      int n;
      logic [1:0] alt_rdy [4];
      logic [9:0] alt_px  [4];
      logic [9:0] alt_py  [4];
      alt_rdy = '{2'b10, 2'b01, 2'b10, 2'b01};
      alt_px  = '{10'd473, 10'd474, 10'd476, 10'd477};
      alt_py  = '{10'd275, 10'd275, 10'd276, 10'd276};

      #3 clr_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pos_x", 32'(pos_x), 32'd464);
      chk("rst_pos_y", 32'(pos_y), 32'd271);
      chk("rst_clk_cursor", 32'(clk_cursor), 32'd0);
      chk("rst_prev", 32'(prev_clk_cursor), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_delta_x", 32'(delta_x), 32'd0);
      clr_n = 1'b1;

      // First step lands on the first tick after release.
      req_dx = {5'd0, 5'd3};
      req_dy = {5'd0, 5'd1};
      slot(2'b01, 2'b01, 5'd3, 5'd1, 10'd467, 10'd272, w);
      chk("first_tick_wait", 32'(w), 32'd7);

      // Tick with nobody valid: the slot is lost and the next request waits a full period.
      e0 = edges;
      wait_tick_slot();
      #1;
      chk("idle_tick_ready", 32'(req_ready), 32'd0);
      chk("idle_tick_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("idle_tick_busy_after", 32'(busy), 32'd0);
      chk("idle_tick_edges", 32'(edges - e0), 32'd0);
      req_dx = {5'd0, 5'd4};
      req_dy = {5'd0, 5'd2};
      slot(2'b01, 2'b01, 5'd4, 5'd2, 10'd471, 10'd274, w);
      chk("idle_next_wait", 32'(w), 32'd7);

      // Contention: last winner was 0, so 1 goes first.
      req_dx = {5'd2, 5'd1};
      req_dy = {5'd1, 5'd0};
      for (int i = 0; i < 4; i++) begin
         slot(2'b11, alt_rdy[i], alt_rdy[i][1] ? 5'd2 : 5'd1, alt_rdy[i][1] ? 5'd1 : 5'd0,
              alt_px[i], alt_py[i], w);
      end
      req_valid = 2'b00;

      // Walk x to 780, then hit the right edge.
      req_dy = '0;
      req_dx = {5'd0, 5'd31};
      for (int k = 1; k <= 9; k++) begin
         slot(2'b01, 2'b01, 5'd31, 5'd0, 10'(477 + 31 * k), 10'd276, w);
      end
      req_dx = {5'd0, 5'd24};
      slot(2'b01, 2'b01, 5'd24, 5'd0, 10'd780, 10'd276, w);
      req_dx = {5'd0, 5'd10};
      slot(2'b01, 2'b01, 5'd3, 5'd0, 10'd783, 10'd276, w);
      req_dx = {5'd0, 5'd5};
      slot(2'b01, 2'b01, 5'd0, 5'd0, 10'd783, 10'd276, w);

      // Recenter coinciding with a tick blocks the grant.
      wait_tick_slot();
      req_dx = {5'd0, 5'd2};
      req_dy = {5'd0, 5'd3};
      req_valid = 2'b01;
      recenter = 1'b1;
      #1;
      chk("recenter_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      recenter = 1'b0;
      @(negedge clk);
      chk("recenter_pos_x", 32'(pos_x), 32'd464);
      chk("recenter_pos_y", 32'(pos_y), 32'd271);
      chk("recenter_busy", 32'(busy), 32'd0);
      slot(2'b01, 2'b01, 5'd2, 5'd3, 10'd466, 10'd274, w);
      chk("recenter_next_wait", 32'(w), 32'd7);

      // Async clear in the middle of a pulse.
      req_dx = {5'd0, 5'd1};
      req_dy = {5'd0, 5'd1};
      req_valid = 2'b01;
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("clr_pre_ready", 32'(req_ready), 32'd1);
      e0 = edges;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      chk("clr_pulse_hi", 32'(clk_cursor), 32'd1);
      #1 clr_n = 1'b0;
      #1;
      chk("clr_clk_cursor", 32'(clk_cursor), 32'd0);
      chk("clr_prev", 32'(prev_clk_cursor), 32'd0);
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_pos_x", 32'(pos_x), 32'd464);
      chk("clr_pos_y", 32'(pos_y), 32'd271);
      chk("clr_delta_x", 32'(delta_x), 32'd0);
      repeat (3) @(negedge clk);
      clr_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("clr_no_edge", 32'(edges - e0), 32'd0);
      chk("clr_idle", 32'(busy), 32'd0);

      // After reset requester 0 wins first contention.
      req_dx = {5'd2, 5'd1};
      req_dy = {5'd1, 5'd0};
      slot(2'b11, 2'b01, 5'd1, 5'd0, 10'd465, 10'd271, w);
      slot(2'b11, 2'b10, 5'd2, 5'd1, 10'd467, 10'd272, w);
      req_valid = 2'b00;
      repeat (4) @(negedge clk);

      chk("ready_protocol", 32'(viol), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
